// File: rtl/reg_files.sv
// reg_files: integer register file for the ID stage of an RV32IM pipeline.
//   2**ADDR_W registers of DATA_W bits, two combinational read ports and one
//   synchronous write port. Register x0 always reads zero.
//
// Optional feature macro: REG_FILES_BYPASS_EN
//   When defined, a write in progress is forwarded to any read port that
//   addresses the same (non-zero) register in the same cycle, outside reset.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-low; clears every register
//   addr1  in   read port 1 address (rs1)
//   addr2  in   read port 2 address (rs2)
//   data1  out  read port 1 data
//   data2  out  read port 2 data
//   we     in   write enable
//   waddr  in   write address (rd)
//   wd     in   write data
module reg_files #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 2 ** ADDR_W;

  // Entry 0 is kept for clean indexing but is never written and never read.
  logic [DATA_W-1:0] r_regs [0:NREG-1];

  logic              w_wr_valid;
  logic [DATA_W-1:0] w_data1;
  logic [DATA_W-1:0] w_data2;

  assign w_wr_valid = we && (waddr != '0);

  // Reset wins over a write presented at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[waddr] <= wd;
    end
  end

  always_comb begin
    w_data1 = '0;
    if (addr1 != '0) begin
      w_data1 = r_regs[addr1];
`ifdef REG_FILES_BYPASS_EN
      // Forward WB data so ID sees the value being written this cycle.
      if (rst && w_wr_valid && (addr1 == waddr)) begin
        w_data1 = wd;
      end
`endif
    end
  end

  always_comb begin
    w_data2 = '0;
    if (addr2 != '0) begin
      w_data2 = r_regs[addr2];
`ifdef REG_FILES_BYPASS_EN
      if (rst && w_wr_valid && (addr2 == waddr)) begin
        w_data2 = wd;
      end
`endif
    end
  end

  assign data1 = w_data1;
  assign data2 = w_data2;

endmodule

// File: tb/tb_reg_files.sv
module tb_reg_files;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

`ifdef REG_FILES_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wd;

  int n_checks = 0;
  int n_fail   = 0;

  reg_files #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr1 (addr1),
    .addr2 (addr2),
    .data1 (data1),
    .data2 (data2),
    .we    (we),
    .waddr (waddr),
    .wd    (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] pre1;   // stored contents seen before the edge (no forwarding)
    logic [31:0] pre2;
    logic [31:0] post1;  // contents after the edge
    logic [31:0] post2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected pre-edge value including forwarding when the bypass build is used.
  function automatic logic [31:0] fwd(input vec_t v, input logic [4:0] a, input logic [31:0] stored);
    if (BYP && v.rst && v.we && v.waddr != 5'd0 && a == v.waddr && a != 5'd0)
      return v.wd;
    return stored;
  endfunction

  logic [31:0] model [32];

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wd = '0; addr1 = '0; addr2 = '0;

    //           rst  we  waddr  wd             a1  a2  pre1          pre2          post1         post2
    vecs[0] = '{1'b1,1'b1,5'd5, 32'hDEADBEEF, 5'd5, 5'd31, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0,1'b0,5'd0, 32'h0,        5'd5, 5'd31, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[2] = '{1'b1,1'b1,5'd5, 32'h12345678, 5'd5, 5'd10, 32'h0,        32'h0,        32'h12345678, 32'h0};
    vecs[3] = '{1'b1,1'b1,5'd10,32'hABCDEF12, 5'd5, 5'd10, 32'h12345678, 32'h0,        32'h12345678, 32'hABCDEF12};
    vecs[4] = '{1'b1,1'b1,5'd0, 32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5] = '{1'b0,1'b1,5'd7, 32'h55AA55AA, 5'd7, 5'd5,  32'h0,        32'h12345678, 32'h0,        32'h0};
    vecs[6] = '{1'b1,1'b1,5'd31,32'h0F0F0F0F, 5'd31,5'd31, 32'h0,        32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F};
    vecs[7] = '{1'b1,1'b1,5'd3, 32'h11111111, 5'd10,5'd3,  32'h0,        32'h0,        32'h0,        32'h11111111};
    vecs[8] = '{1'b1,1'b1,5'd10,32'h22222222, 5'd10,5'd3,  32'h0,        32'h11111111, 32'h22222222, 32'h11111111};

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    addr1 = 5'd1; addr2 = 5'd31;
    #1;
    check("reset_state_d1", data1, 32'h0);
    check("reset_state_d2", data2, 32'h0);

    // Table: drive after an edge, sample pre-edge on negedge, sample post-edge after.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; we = vecs[i].we; waddr = vecs[i].waddr; wd = vecs[i].wd;
      addr1 = vecs[i].a1; addr2 = vecs[i].a2;
      @(negedge clk);
      check($sformatf("v%0d_pre_d1", i), data1, fwd(vecs[i], vecs[i].a1, vecs[i].pre1));
      check($sformatf("v%0d_pre_d2", i), data2, fwd(vecs[i], vecs[i].a2, vecs[i].pre2));
      @(posedge clk);
      #1;
      we = 1'b0; rst = 1'b1;
      #1;
      check($sformatf("v%0d_post_d1", i), data1, vecs[i].post1);
      check($sformatf("v%0d_post_d2", i), data2, vecs[i].post2);
    end

    // Same address on both ports, then wd wiggles with we low: outputs hold.
    addr1 = 5'd31; addr2 = 5'd31; waddr = 5'd31; we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wd = 32'hC0DE0000 + k;
      @(negedge clk);
      check($sformatf("hold_d1_%0d", k), data1, 32'h0F0F0F0F);
      check($sformatf("hold_d2_%0d", k), data2, 32'h0F0F0F0F);
      @(posedge clk);
      #1;
      check($sformatf("hold_post_d1_%0d", k), data1, 32'h0F0F0F0F);
    end

    // Fill every register and read each back through both ports.
    model[0] = 32'h0;
    for (int r = 1; r < 32; r++) begin
      model[r] = (32'h01010101 * r) ^ 32'hA5A50000;
      we = 1'b1; waddr = 5'(r); wd = model[r];
      @(posedge clk);
      #1;
    end
    we = 1'b0;
    for (int r = 0; r < 32; r++) begin
      addr1 = 5'(r); addr2 = 5'(31 - r);
      #1;
      check($sformatf("fill_d1_r%0d", r), data1, model[r]);
      check($sformatf("fill_d2_r%0d", 31 - r), data2, model[31 - r]);
    end

    // Reset clears the whole array; contents hold until the edge.
    rst = 1'b0; addr1 = 5'd17; addr2 = 5'd30;
    #1;
    check("pre_reset_hold_d1", data1, model[17]);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int r = 0; r < 32; r++) begin
      addr1 = 5'(r); addr2 = 5'(31 - r);
      #1;
      check($sformatf("clear_d1_r%0d", r), data1, 32'h0);
      check($sformatf("clear_d2_r%0d", 31 - r), data2, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
